// File: rtl/mem_bus_master.sv
// Initiator for the shared memory bus: turns single-outstanding core requests into
// mrd/mwr cycles with programmable wait states and a turnaround gap before the next accept.
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 7
`endif

module mem_bus_master #(
  parameter int ADDR_W     = `MEMORY_SIZE_ENC + 1,
  parameter int DATA_W     = `MEMORY_SIZE_ENC + 1,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 1,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire logic [DATA_W-1:0] mem_data,
  output logic              mrd,
  output logic              mwr
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int TURN_W   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0]  WR_LOAD   = CNT_W'(WR_WAIT - 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam state_t AFTER_ACC = (TURNAROUND > 0) ? TURN : IDLE;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [TURN_W-1:0]   turn_cnt_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_valid_r;
  logic                mrd_r;
  logic                mwr_r;
  logic                oe_r;
  logic                req_ready_r;
  logic                busy_r;
  logic                accept_s;
  logic                done_s;
  logic                mrd_nxt_s;
  logic                mwr_nxt_s;
  logic                oe_nxt_s;
  logic                ready_nxt_s;

  assign accept_s = (state_r == IDLE) && req_valid;
  assign done_s   = ((state_r == RD) || (state_r == WR)) && (cnt_r == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = req_write ? WR : RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD, WR: begin
        if (cnt_r == '0) begin
          state_nxt_s = AFTER_ACC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      TURN: begin
        if (turn_cnt_r == '0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TURN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Strobe/enable values for the coming cycle, registered below
  always_comb begin
    mrd_nxt_s   = (state_nxt_s == RD);
    mwr_nxt_s   = (state_nxt_s == WR);
    oe_nxt_s    = (state_nxt_s == WR);
    ready_nxt_s = (state_nxt_s == IDLE);
  end

  // Registered bus strobes and handshake status
  always_ff @(posedge clk) begin
    if (rst) begin
      mrd_r       <= 1'b0;
      mwr_r       <= 1'b0;
      oe_r        <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      mrd_r       <= mrd_nxt_s;
      mwr_r       <= mwr_nxt_s;
      oe_r        <= oe_nxt_s;
      req_ready_r <= ready_nxt_s;
      busy_r      <= !ready_nxt_s;
    end
  end

  // Request capture, wait/turnaround counters and response
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      turn_cnt_r  <= {TURN_W{1'b0}};
    end else begin
      rsp_valid_r <= done_s;
      if (accept_s) begin
        mem_addr_r <= req_addr;
        wdata_r    <= req_wdata;
        cnt_r      <= req_write ? WR_LOAD : RD_LOAD;
      end else if (((state_r == RD) || (state_r == WR)) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      // Read data is sampled while the responder still sees mrd high
      if (done_s && (state_r == RD)) begin
        rsp_rdata_r <= mem_data;
      end
      if (done_s) begin
        turn_cnt_r <= TURN_LOAD;
      end else if ((state_r == TURN) && (turn_cnt_r != '0)) begin
        turn_cnt_r <= turn_cnt_r - TURN_W'(1);
      end
    end
  end

  assign mem_data  = oe_r ? wdata_r : {DATA_W{1'bz}};
  assign mem_addr  = mem_addr_r;
  assign mrd       = mrd_r;
  assign mwr       = mwr_r;
  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: directed scenarios plus random traffic, each cycle checked
// against a timeline model (handshake cycle + wait/turnaround arithmetic) and a reference memory.
module tb_mem_bus_master;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int RDW = 3;
  localparam int WRW = 2;
  localparam int TA  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = 8'h00;
  logic [DW-1:0] req_wdata = 8'h00;
  wire           req_ready;
  wire           rsp_valid;
  wire  [DW-1:0] rsp_rdata;
  wire           busy;
  wire  [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  wire           mrd;
  wire           mwr;

  always #5 clk = ~clk;

  mem_bus_master #(
    .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW), .TURNAROUND(TA)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mrd(mrd), .mwr(mwr)
  );

  // Memory responder on the bus
  logic [DW-1:0] mem_tb [256];
  assign mem_data = mrd ? mem_tb[mem_addr] : {DW{1'bz}};
  always @(posedge clk) if (mwr) mem_tb[mem_addr] <= mem_data;

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            cyc = 0;
  int            acc_n = 0;
  int            next_accept = 0;
  bit            have_acc = 1'b0;
  bit            acc_w = 1'b0;
  logic [AW-1:0] acc_addr = 8'h00;
  logic [AW-1:0] last_addr = 8'h00;
  logic [DW-1:0] acc_data = 8'h00;
  logic [DW-1:0] last_rdata = 8'h00;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One bus cycle: check this cycle's outputs, then drive inputs for the closing edge
  task automatic step(input bit r, input bit v, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    int wt;
    bit active;
    bit ready_exp;
    @(negedge clk);
    wt        = acc_w ? WRW : RDW;
    active    = have_acc && (cyc > acc_n) && (cyc <= acc_n + wt);
    ready_exp = (cyc >= next_accept);
    check_eq("req_ready", {31'd0, req_ready}, {31'd0, ready_exp});
    check_eq("busy",      {31'd0, busy},      {31'd0, !ready_exp});
    check_eq("mrd",       {31'd0, mrd},       {31'd0, active && !acc_w});
    check_eq("mwr",       {31'd0, mwr},       {31'd0, active && acc_w});
    check_eq("rsp_valid", {31'd0, rsp_valid}, {31'd0, have_acc && (cyc == acc_n + wt + 1)});
    check_eq("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, last_rdata});
    check_eq("mem_addr",  {24'd0, mem_addr},  {24'd0, last_addr});
    if (active && acc_w) check_eq("mem_data", {24'd0, mem_data}, {24'd0, acc_data});

    rst = r; req_valid = v; req_write = w; req_addr = a; req_wdata = d;

    if (r) begin
      have_acc    = 1'b0;
      next_accept = cyc + 1;
      last_addr   = 8'h00;
      last_rdata  = 8'h00;
    end else begin
      if (have_acc && !acc_w && (cyc == acc_n + wt)) last_rdata = ref_mem[acc_addr];
      if (v && (cyc >= next_accept)) begin
        have_acc    = 1'b1;
        acc_n       = cyc;
        acc_w       = w;
        acc_addr    = a;
        acc_data    = d;
        last_addr   = a;
        if (w) ref_mem[a] = d;
        next_accept = cyc + (w ? WRW : RDW) + 1 + TA;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_tb[i]  = 8'hFF;
      ref_mem[i] = 8'hFF;
    end

    // Reset held two cycles
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);

    // Write 0x3C to 0x05, read it back, read an unwritten location
    step(1'b0, 1'b1, 1'b1, 8'h05, 8'h3C);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    idle(6);
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    idle(6);

    // req_valid held: write then read back-to-back
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'h20, 8'hA5);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    idle(6);

    // Reset during the second read wait cycle aborts the access
    step(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(6);

    // Request inputs wiggling during the write wait cycles
    step(1'b0, 1'b1, 1'b1, 8'h33, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'hC4, 8'h81);
    step(1'b0, 1'b0, 1'b0, 8'h7E, 8'h18);
    idle(4);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 31)),
           8'($urandom_range(0, 255)));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
